// File: rtl/boc_sig_gen_pkg.sv
// rtl/boc_sig_gen_pkg.sv - shared types, B1 defaults and carrier cosine table for boc_sig_gen
`timescale 1ns/1ps
package boc_sig_gen_pkg;

  localparam int ACC_WIDTH_DEF     = 32;
  localparam int PRN_LEN_DEF       = 4092;
  localparam int PRN_PHS_WIDTH_DEF = 12;
  localparam int HALF_WIDTH_DEF    = 13;

  localparam logic [31:0] CAR_FCW_NOM = 32'd1342177280;
  localparam logic [31:0] PRN_FCW_NOM = 32'd274609472;

  // Magnitudes stay within 127 so negating an entry always fits in 8 bits.
  localparam logic signed [7:0] COS_LUT [0:7] = '{
    8'sd127, 8'sd90, 8'sd0, -8'sd90, -8'sd127, -8'sd90, 8'sd0, 8'sd90
  };

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

endpackage

// File: rtl/boc_code_nco.sv
// rtl/boc_code_nco.sv - half-chip code NCO: phase accumulator, half-chip counter, period wrap and sop flag
`timescale 1ns/1ps
module boc_code_nco
  import boc_sig_gen_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int PRN_LEN    = PRN_LEN_DEF,
  parameter int HALF_WIDTH = HALF_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  input  logic [HALF_WIDTH-1:0] init_phs,
  input  logic [ACC_WIDTH-1:0]  prn_fcw,
  output logic [HALF_WIDTH-1:0] half_cnt,
  output logic                  wrap,
  output logic                  sop_pend
);

  localparam logic [HALF_WIDTH-1:0] HALF_NUM  = HALF_WIDTH'(2 * PRN_LEN);
  localparam logic [HALF_WIDTH-1:0] HALF_LAST = HALF_WIDTH'(2 * PRN_LEN - 1);

  logic [ACC_WIDTH-1:0]  code_acc_q, code_acc_d;
  logic [HALF_WIDTH-1:0] half_cnt_q, half_cnt_d;
  logic                  sop_pend_q, sop_pend_d;
  logic [ACC_WIDTH:0]    sum;

  always_comb begin
    sum        = {1'b0, code_acc_q} + {1'b0, prn_fcw};
    wrap       = adv && sum[ACC_WIDTH] && (half_cnt_q == HALF_LAST);
    code_acc_d = code_acc_q;
    half_cnt_d = half_cnt_q;
    sop_pend_d = sop_pend_q;
    if (load) begin
      code_acc_d = '0;
      half_cnt_d = (init_phs < HALF_NUM) ? init_phs : '0;
      sop_pend_d = (half_cnt_d == '0);
    end else if (adv) begin
      code_acc_d = sum[ACC_WIDTH-1:0];
      if (sum[ACC_WIDTH]) begin
        half_cnt_d = (half_cnt_q == HALF_LAST) ? '0 : half_cnt_q + 1'b1;
      end
      // Every advancing cycle emits a sample, so a pending sop is consumed here.
      sop_pend_d = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_acc_q <= '0;
      half_cnt_q <= '0;
      sop_pend_q <= 1'b0;
    end else begin
      code_acc_q <= code_acc_d;
      half_cnt_q <= half_cnt_d;
      sop_pend_q <= sop_pend_d;
    end
  end

  assign half_cnt = half_cnt_q;
  assign sop_pend = sop_pend_q;

endmodule

// File: rtl/boc_sig_gen.sv
// rtl/boc_sig_gen.sv - B1 BOC(1,1) IF test-signal generator with carrier NCO, PRN memory and nav bit path
`timescale 1ns/1ps
module boc_sig_gen
  import boc_sig_gen_pkg::*;
#(
  parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
  parameter int PRN_LEN       = PRN_LEN_DEF,
  parameter int PRN_PHS_WIDTH = PRN_PHS_WIDTH_DEF,
  parameter int HALF_WIDTH    = HALF_WIDTH_DEF
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic                     rx_start,
  input  logic                     rx_stop,
  input  logic [ACC_WIDTH-1:0]     rx_car_fcw,
  input  logic [ACC_WIDTH-1:0]     rx_prn_fcw,
  input  logic [HALF_WIDTH-1:0]    rx_init_phs,
  input  logic [1:0]               rx_amp_shift,
  input  logic                     rx_prn_wr_en,
  input  logic [PRN_PHS_WIDTH-1:0] rx_prn_wr_addr,
  input  logic                     rx_prn_wr_data,
  input  logic                     rx_nav_bit,
  input  logic                     rx_nav_valid,
  output logic                     tx_nav_ready,
  output logic [7:0]               tx_src,
  output logic                     tx_src_valid,
  output logic                     tx_prn_sop,
  output logic [PRN_PHS_WIDTH-1:0] tx_prn_phs,
  output logic                     tx_nav_underrun,
  output logic                     tx_busy
);

  state_e                   state_q, state_d;
  logic [ACC_WIDTH-1:0]     car_acc_q, car_acc_d;
  logic                     cur_bit_q, cur_bit_d;
  logic                     next_bit_q, next_bit_d;
  logic                     next_valid_q, next_valid_d;
  logic                     underrun_q, underrun_d;
  logic [7:0]               src_q, src_d;
  logic                     src_valid_q, src_valid_d;
  logic                     sop_q, sop_d;
  logic [PRN_PHS_WIDTH-1:0] phs_q, phs_d;

  logic                     prn_mem [PRN_LEN];
  logic                     load, adv, wrap, sop_pend, sym;
  logic [HALF_WIDTH-1:0]    half_cnt;
  logic [PRN_PHS_WIDTH-1:0] chip;
  logic signed [7:0]        cos_val, signed_val, shifted;

  assign load = (state_q == IDLE) && rx_start;
  assign adv  = (state_q == RUN) && !rx_stop;

  boc_code_nco #(
    .ACC_WIDTH (ACC_WIDTH),
    .PRN_LEN   (PRN_LEN),
    .HALF_WIDTH(HALF_WIDTH)
  ) u_code_nco (
    .clk     (rx_clk),
    .rst     (rx_rst),
    .load    (load),
    .adv     (adv),
    .init_phs(rx_init_phs),
    .prn_fcw (rx_prn_fcw),
    .half_cnt(half_cnt),
    .wrap    (wrap),
    .sop_pend(sop_pend)
  );

  // PRN memory keeps its contents across reset; loads are only accepted while idle.
  always_ff @(posedge rx_clk) begin
    if ((state_q == IDLE) && rx_prn_wr_en && (rx_prn_wr_addr < PRN_PHS_WIDTH'(PRN_LEN))) begin
      prn_mem[rx_prn_wr_addr] <= rx_prn_wr_data;
    end
  end

  always_comb begin
    chip       = PRN_PHS_WIDTH'(half_cnt >> 1);
    cos_val    = COS_LUT[car_acc_q[ACC_WIDTH-1 -: 3]];
    sym        = prn_mem[chip] ^ half_cnt[0] ^ cur_bit_q;
    signed_val = sym ? -cos_val : cos_val;
    shifted    = signed_val >>> rx_amp_shift;
  end

  always_comb begin
    state_d      = state_q;
    car_acc_d    = car_acc_q;
    cur_bit_d    = cur_bit_q;
    next_bit_d   = next_bit_q;
    next_valid_d = next_valid_q;
    underrun_d   = underrun_q;
    src_d        = '0;
    src_valid_d  = 1'b0;
    sop_d        = 1'b0;
    phs_d        = phs_q;
    case (state_q)
      IDLE: begin
        if (rx_start) begin
          state_d    = RUN;
          car_acc_d  = '0;
          cur_bit_d  = 1'b0;
          underrun_d = 1'b0;
        end
      end
      RUN: begin
        if (rx_stop) begin
          state_d = IDLE;
        end else begin
          car_acc_d   = car_acc_q + rx_car_fcw;
          src_d       = shifted;
          src_valid_d = 1'b1;
          sop_d       = sop_pend;
          phs_d       = chip;
          if (wrap) begin
            if (next_valid_q) begin
              cur_bit_d    = next_bit_q;
              next_valid_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is only offered when the holding register is empty, so capture never collides with consume.
    if (rx_nav_valid && !next_valid_q) begin
      next_bit_d   = rx_nav_bit;
      next_valid_d = 1'b1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q      <= IDLE;
      car_acc_q    <= '0;
      cur_bit_q    <= 1'b0;
      next_bit_q   <= 1'b0;
      next_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      src_q        <= '0;
      src_valid_q  <= 1'b0;
      sop_q        <= 1'b0;
      phs_q        <= '0;
    end else begin
      state_q      <= state_d;
      car_acc_q    <= car_acc_d;
      cur_bit_q    <= cur_bit_d;
      next_bit_q   <= next_bit_d;
      next_valid_q <= next_valid_d;
      underrun_q   <= underrun_d;
      src_q        <= src_d;
      src_valid_q  <= src_valid_d;
      sop_q        <= sop_d;
      phs_q        <= phs_d;
    end
  end

  assign tx_nav_ready    = !next_valid_q;
  assign tx_src          = src_q;
  assign tx_src_valid    = src_valid_q;
  assign tx_prn_sop      = sop_q;
  assign tx_prn_phs      = phs_q;
  assign tx_nav_underrun = underrun_q;
  assign tx_busy         = (state_q == RUN);

endmodule

// File: tb/tb_boc_sig_gen.sv
// tb/tb_boc_sig_gen.sv - scoreboard testbench for boc_sig_gen
`timescale 1ns/1ps
module tb_boc_sig_gen;
  import boc_sig_gen_pkg::*;

  logic        rx_clk = 1'b0;
  logic        rx_rst, rx_start, rx_stop;
  logic [31:0] rx_car_fcw, rx_prn_fcw;
  logic [12:0] rx_init_phs;
  logic [1:0]  rx_amp_shift;
  logic        rx_prn_wr_en, rx_prn_wr_data, rx_nav_bit, rx_nav_valid;
  logic [11:0] rx_prn_wr_addr;
  logic        tx_nav_ready, tx_src_valid, tx_prn_sop, tx_nav_underrun, tx_busy;
  logic [7:0]  tx_src;
  logic [11:0] tx_prn_phs;

  typedef struct packed {
    logic [7:0]  src;
    logic        sop;
    logic [11:0] phs;
  } samp_t;

  samp_t exp_q[$];
  samp_t got_e;
  logic  tb_prn [4092];
  logic  tb_nav [4];
  int    lut [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
  int    checks = 0;
  int    failures = 0;
  int    n_seen = 0;

  always #5 rx_clk = ~rx_clk;

  boc_sig_gen dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_start(rx_start), .rx_stop(rx_stop),
    .rx_car_fcw(rx_car_fcw), .rx_prn_fcw(rx_prn_fcw), .rx_init_phs(rx_init_phs),
    .rx_amp_shift(rx_amp_shift), .rx_prn_wr_en(rx_prn_wr_en), .rx_prn_wr_addr(rx_prn_wr_addr),
    .rx_prn_wr_data(rx_prn_wr_data), .rx_nav_bit(rx_nav_bit), .rx_nav_valid(rx_nav_valid),
    .tx_nav_ready(tx_nav_ready), .tx_src(tx_src), .tx_src_valid(tx_src_valid),
    .tx_prn_sop(tx_prn_sop), .tx_prn_phs(tx_prn_phs), .tx_nav_underrun(tx_nav_underrun),
    .tx_busy(tx_busy)
  );

  // Closed-form expectation for the k-th sample after start.
  function automatic samp_t model(int k, logic [31:0] car, logic [31:0] pf, int init, int amp);
    samp_t  r;
    longint pf64, car64, ie, tot, totp;
    int     half, per, cidx, v;
    logic   s;
    pf64  = longint'({32'h0, pf});
    car64 = longint'({32'h0, car});
    ie    = (init >= 8184) ? 0 : init;
    tot   = ie + ((longint'(k) * pf64) >> 32);
    totp  = ie + ((longint'(k - 1) * pf64) >> 32);
    half  = int'(tot % 8184);
    per   = int'(tot / 8184);
    if (per > 3) per = 3;
    cidx  = int'(((longint'(k) * car64) & 64'hFFFF_FFFF) >> 29);
    s     = tb_prn[half / 2] ^ half[0] ^ tb_nav[per];
    v     = s ? -lut[cidx] : lut[cidx];
    v     = v >>> amp;
    r.src = v[7:0];
    r.phs = 12'(half / 2);
    r.sop = (half == 0) && ((k == 0) || ((totp % 8184) != 0));
    return r;
  endfunction

  always @(negedge rx_clk) begin
    if (tx_src_valid === 1'b1) begin
      n_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sample_unexpected: got src=%0d sop=%0b phs=%0d, required no sample", $signed(tx_src), tx_prn_sop, tx_prn_phs);
      end else begin
        got_e = exp_q.pop_front();
        if ({tx_src, tx_prn_sop, tx_prn_phs} !== got_e) begin
          failures++;
          $display("FAIL sample_%0d: got src=%0d sop=%0b phs=%0d, required src=%0d sop=%0b phs=%0d",
                   n_seen - 1, $signed(tx_src), tx_prn_sop, tx_prn_phs, $signed(got_e.src), got_e.sop, got_e.phs);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic load_prn_zero;
    for (int a = 0; a < 4092; a++) begin
      @(posedge rx_clk); #1;
      rx_prn_wr_en = 1'b1; rx_prn_wr_addr = 12'(a); rx_prn_wr_data = 1'b0;
      tb_prn[a] = 1'b0;
    end
    @(posedge rx_clk); #1;
    rx_prn_wr_en = 1'b0;
  endtask

  task automatic wr_prn(input logic [11:0] a, input logic d);
    @(posedge rx_clk); #1;
    rx_prn_wr_en = 1'b1; rx_prn_wr_addr = a; rx_prn_wr_data = d;
    @(posedge rx_clk); #1;
    rx_prn_wr_en = 1'b0;
  endtask

  task automatic start_run(input int init, input logic [31:0] car, input logic [31:0] pf, input int amp, input int n);
    rx_init_phs = init[12:0]; rx_car_fcw = car; rx_prn_fcw = pf; rx_amp_shift = amp[1:0];
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(model(k, car, pf, init, amp));
    n_seen = 0;
    @(posedge rx_clk); #1; rx_start = 1'b1;
    @(posedge rx_clk); #1; rx_start = 1'b0;
  endtask

  task automatic wait_samples(input int target, input string name);
    int cyc = 0;
    while (n_seen < target && cyc < target + 64) begin
      @(posedge rx_clk);
      cyc++;
    end
    checks++;
    if (n_seen < target) begin
      failures++;
      $display("FAIL %s_timeout: got %0d samples, required %0d", name, n_seen, target);
    end
  endtask

  task automatic stop_run;
    @(posedge rx_clk); #1; rx_stop = 1'b1;
    @(posedge rx_clk); #1; rx_stop = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rx_rst = 1'b1; rx_start = 1'b0; rx_stop = 1'b0;
    rx_car_fcw = CAR_FCW_NOM; rx_prn_fcw = PRN_FCW_NOM; rx_init_phs = '0; rx_amp_shift = '0;
    rx_prn_wr_en = 1'b0; rx_prn_wr_addr = '0; rx_prn_wr_data = 1'b0;
    rx_nav_bit = 1'b0; rx_nav_valid = 1'b0;
    for (int i = 0; i < 4; i++) tb_nav[i] = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1; rx_rst = 1'b0;
    checks++;
    if ({tx_src, tx_src_valid, tx_prn_sop, tx_prn_phs, tx_nav_underrun, tx_busy} !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs: got src=%0d valid=%0b sop=%0b phs=%0d underrun=%0b busy=%0b, required all 0",
               $signed(tx_src), tx_src_valid, tx_prn_sop, tx_prn_phs, tx_nav_underrun, tx_busy);
    end
    checks++;
    if (tx_nav_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_nav_ready: got %0b, required 1", tx_nav_ready);
    end
  endtask

  task automatic test_basic;
    load_prn_zero();
    start_run(0, 32'd0, 32'h8000_0000, 0, 16368 + 16);
    wait_samples(20, "basic_start");
    checks++;
    if (tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %0b, required 1", tx_busy);
    end
    wait_samples(16368 + 4, "basic_period");
    stop_run();
  endtask

  task automatic test_prn_amp;
    wr_prn(12'd1, 1'b1);
    tb_prn[1] = 1'b1;
    start_run(0, 32'd0, 32'h8000_0000, 0, 24);
    wait_samples(16, "prn_chip");
    stop_run();
    start_run(0, 32'd0, 32'h8000_0000, 2, 24);
    wait_samples(16, "amp_shift");
    stop_run();
    wr_prn(12'd1, 1'b0);
    tb_prn[1] = 1'b0;
  endtask

  task automatic test_init_phs;
    start_run(8182, 32'd0, 32'h8000_0000, 0, 24);
    wait_samples(12, "init_8182");
    stop_run();
    start_run(8190, 32'd0, 32'h8000_0000, 0, 24);
    wait_samples(12, "init_out_of_range");
    stop_run();
  endtask

  task automatic test_carrier;
    start_run(0, 32'h2000_0000, 32'd0, 0, 24);
    wait_samples(16, "carrier_lut");
    stop_run();
  endtask

  task automatic test_nav;
    tb_nav[0] = 1'b0; tb_nav[1] = 1'b1; tb_nav[2] = 1'b1; tb_nav[3] = 1'b1;
    checks++;
    if (tx_nav_ready !== 1'b1) begin
      failures++;
      $display("FAIL nav_ready_empty: got %0b, required 1", tx_nav_ready);
    end
    @(posedge rx_clk); #1; rx_nav_bit = 1'b1; rx_nav_valid = 1'b1;
    @(posedge rx_clk); #1; rx_nav_bit = 1'b0; rx_nav_valid = 1'b0;
    checks++;
    if (tx_nav_ready !== 1'b0) begin
      failures++;
      $display("FAIL nav_ready_full: got %0b, required 0", tx_nav_ready);
    end
    start_run(8180, 32'd0, 32'hFFFF_FFFF, 0, 8210);
    wait_samples(100, "nav_period1");
    checks++;
    if ({tx_nav_underrun, tx_nav_ready} !== 2'b01) begin
      failures++;
      $display("FAIL nav_consumed: got underrun=%0b ready=%0b, required underrun=0 ready=1", tx_nav_underrun, tx_nav_ready);
    end
    wait_samples(8195, "nav_period2");
    checks++;
    if (tx_nav_underrun !== 1'b1) begin
      failures++;
      $display("FAIL nav_underrun: got %0b, required 1", tx_nav_underrun);
    end
    stop_run();
    for (int i = 0; i < 4; i++) tb_nav[i] = 1'b0;
  endtask

  task automatic test_control;
    start_run(0, 32'd0, 32'h8000_0000, 0, 40);
    wait_samples(10, "stop_pre");
    @(posedge rx_clk); #1; rx_stop = 1'b1;
    @(posedge rx_clk); #1; rx_stop = 1'b0;
    exp_q.delete();
    checks++;
    if ({tx_src_valid, tx_busy, tx_src, tx_prn_sop} !== 11'h0) begin
      failures++;
      $display("FAIL stop_clears: got valid=%0b busy=%0b src=%0d sop=%0b, required all 0", tx_src_valid, tx_busy, $signed(tx_src), tx_prn_sop);
    end
    start_run(0, 32'd0, 32'h8000_0000, 0, 40);
    wait_samples(4, "run_write_pre");
    wr_prn(12'd0, 1'b1);
    wait_samples(20, "run_write_during");
    stop_run();
    start_run(0, 32'd0, 32'h8000_0000, 0, 24);
    wait_samples(16, "run_write_after");
    @(posedge rx_clk); #1; rx_nav_bit = 1'b1; rx_nav_valid = 1'b1;
    @(posedge rx_clk); #1; rx_nav_valid = 1'b0; rx_rst = 1'b1;
    @(posedge rx_clk); #1; rx_rst = 1'b0;
    exp_q.delete();
    checks++;
    if ({tx_src, tx_src_valid, tx_prn_sop, tx_prn_phs, tx_nav_underrun, tx_busy, tx_nav_ready} !== 25'h1) begin
      failures++;
      $display("FAIL reset_mid_run: got src=%0d valid=%0b sop=%0b phs=%0d underrun=%0b busy=%0b ready=%0b, required zeros and ready=1",
               $signed(tx_src), tx_src_valid, tx_prn_sop, tx_prn_phs, tx_nav_underrun, tx_busy, tx_nav_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prn_amp();
    test_init_phs();
    test_carrier();
    test_nav();
    test_control();
    repeat (4) @(posedge rx_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
